// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: register map,
// CTRL/STATUS bit positions, FSM state encoding and a STATUS packer.
package ccff_loader_pkg;

  localparam int WORD_W   = 32;
  localparam int BITCNT_W = 20;

  // Register offsets, decoded from byte address bits [3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BITCNT = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // CTRL bit indices
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_PRST  = 2;

  // STATUS bit indices
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_EMPTY   = 3;
  localparam int ST_STALLED = 4;
  localparam int ST_OVF     = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } ccff_state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic full, input logic empty,
                                              input logic stalled, input logic ovf);
    logic [31:0] w;
    w             = 32'h0;
    w[ST_BUSY]    = busy;
    w[ST_DONE]    = done;
    w[ST_FULL]    = full;
    w[ST_EMPTY]   = empty;
    w[ST_STALLED] = stalled;
    w[ST_OVF]     = ovf;
    return w;
  endfunction

endpackage

// File: rtl/ccff_word_fifo.sv
// Small synchronous FIFO for bitstream words. Show-ahead read port:
// rdata always presents the oldest entry. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ccff_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against current occupancy
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == '0);
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush acts as a synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Wishbone-controlled loader that streams a bitstream from a word FIFO
// into a configuration flip-flop chain (LSB first), generating prog_clk.
// Optional feature macro CCFF_READBACK_EN: capture ccff_tail on every
// prog_clk rising edge into a 32-bit register readable through DATA.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk,
  output logic        prog_reset,
  output logic        ccff_head,
  input  logic        ccff_tail
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

  // Bus-side signals
  logic                wb_req_s;
  logic                wr_s;
  logic                rd_s;
  logic [1:0]          sel_s;
  logic                start_s;
  logic                abort_s;
  logic                push_s;
  logic                ack_r;
  logic [31:0]         dat_r;
  logic [31:0]         rd_data_s;
  logic [31:0]         rb_data_s;

  // Configuration/status registers
  logic                prst_r;
  logic [BITCNT_W-1:0] bitcnt_r;
  logic                done_r;
  logic                ovf_r;

  // FSM / datapath
  ccff_state_e         state_r, state_next_s;
  logic [7:0]          div_cnt_r, div_next_s;
  logic [BITCNT_W-1:0] rem_r, rem_next_s;
  logic [4:0]          idx_r, idx_next_s;
  logic [WORD_W-1:0]   shift_r, shift_next_s;
  logic                pop_s;
  logic                prog_clk_r;
  logic                head_r;
  logic                busy_s;
  logic                stalled_s;
  logic                start_ok_s;

  // FIFO
  logic [WORD_W-1:0]   fifo_rdata_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CW-1:0]       fifo_count_s;

  logic                unused_s;
  assign unused_s = &{1'b0, wbs_adr_i[1:0], fifo_count_s, ccff_tail};

  // One request per transfer: a held strobe is ignored while ack is high
  assign wb_req_s   = wbs_stb_i & wbs_cyc_i & ~ack_r;
  assign wr_s       = wb_req_s & wbs_we_i;
  assign rd_s       = wb_req_s & ~wbs_we_i;
  assign sel_s      = wbs_adr_i[3:2];
  assign start_s    = wr_s & (sel_s == REG_CTRL) & wbs_dat_i[CTRL_START];
  assign abort_s    = wr_s & (sel_s == REG_CTRL) & wbs_dat_i[CTRL_ABORT];
  assign push_s     = wr_s & (sel_s == REG_DATA);
  assign start_ok_s = start_s & ~abort_s & (state_r == S_IDLE);

  assign busy_s    = (state_r == S_FETCH) || (state_r == S_SHIFT_LO) ||
                     (state_r == S_SHIFT_HI);
  assign stalled_s = (state_r == S_FETCH) && fifo_empty_s;

  ccff_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (abort_s),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wbs_dat_i),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Read-data multiplexer for the register map
  always_comb begin
    rd_data_s = 32'h0;
    case (sel_s)
      REG_CTRL:   rd_data_s = 32'h0;
      REG_STATUS: rd_data_s = pack_status(busy_s, done_r, fifo_full_s,
                                          fifo_empty_s, stalled_s, ovf_r);
      REG_BITCNT: rd_data_s = {12'h0, bitcnt_r};
      REG_DATA:   rd_data_s = rb_data_s;
      default:    rd_data_s = 32'h0;
    endcase
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0;
    end else begin
      ack_r <= wb_req_s;
      dat_r <= rd_s ? rd_data_s : 32'h0;
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prst_r   <= 1'b0;
      bitcnt_r <= '0;
    end else begin
      if (wr_s && (sel_s == REG_CTRL)) begin
        prst_r <= wbs_dat_i[CTRL_PRST];
      end
      if (wr_s && (sel_s == REG_BITCNT)) begin
        bitcnt_r <= wbs_dat_i[BITCNT_W-1:0];
      end
    end
  end

  // Sticky done and overflow flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      if (abort_s || start_ok_s) begin
        done_r <= 1'b0;
      end else if (state_r == S_DONE) begin
        done_r <= 1'b1;
      end
      if (start_ok_s) begin
        ovf_r <= 1'b0;
      end else if (push_s && fifo_full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FSM next-state and shift datapath; abort overrides everything
  always_comb begin
    state_next_s = state_r;
    div_next_s   = div_cnt_r;
    rem_next_s   = rem_r;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    pop_s        = 1'b0;
    if (abort_s) begin
      state_next_s = S_IDLE;
      div_next_s   = 8'd0;
      rem_next_s   = '0;
      idx_next_s   = 5'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            if (bitcnt_r != '0) begin
              state_next_s = S_FETCH;
              rem_next_s   = bitcnt_r;
            end else begin
              state_next_s = S_DONE;
            end
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_FETCH: begin
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            shift_next_s = fifo_rdata_s;
            idx_next_s   = 5'd0;
            div_next_s   = 8'd0;
            state_next_s = S_SHIFT_LO;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_SHIFT_LO: begin
          if (div_cnt_r == DIV_LAST) begin
            div_next_s   = 8'd0;
            state_next_s = S_SHIFT_HI;
          end else begin
            div_next_s   = div_cnt_r + 8'd1;
          end
        end
        S_SHIFT_HI: begin
          if (div_cnt_r == DIV_LAST) begin
            div_next_s   = 8'd0;
            shift_next_s = {1'b0, shift_r[WORD_W-1:1]};
            rem_next_s   = rem_r - 20'd1;
            idx_next_s   = idx_r + 5'd1;
            if (rem_r == 20'd1) begin
              state_next_s = S_DONE;
            end else if (idx_r == 5'd31) begin
              state_next_s = S_FETCH;
            end else begin
              state_next_s = S_SHIFT_LO;
            end
          end else begin
            div_next_s   = div_cnt_r + 8'd1;
          end
        end
        S_DONE: begin
          state_next_s = S_IDLE;
        end
        default: begin
          state_next_s = S_IDLE;
        end
      endcase
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r   <= S_IDLE;
      div_cnt_r <= 8'd0;
      rem_r     <= '0;
      idx_r     <= 5'd0;
      shift_r   <= '0;
    end else begin
      state_r   <= state_next_s;
      div_cnt_r <= div_next_s;
      rem_r     <= rem_next_s;
      idx_r     <= idx_next_s;
      shift_r   <= shift_next_s;
    end
  end

  // Chain outputs come straight from flops so they cannot glitch
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prog_clk_r <= 1'b0;
      head_r     <= 1'b0;
    end else begin
      prog_clk_r <= (state_next_s == S_SHIFT_HI);
      head_r     <= ((state_next_s == S_SHIFT_LO) || (state_next_s == S_SHIFT_HI)) ?
                    shift_next_s[0] : 1'b0;
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_r;

  // Capture the chain output at each prog_clk rising edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rb_r <= '0;
    end else if ((state_r == S_SHIFT_LO) && (state_next_s == S_SHIFT_HI)) begin
      rb_r <= {ccff_tail, rb_r[WORD_W-1:1]};
    end
  end

  assign rb_data_s = rb_r;
`else
  assign rb_data_s = 32'h0;
`endif

  assign wbs_ack_o  = ack_r;
  assign wbs_dat_o  = dat_r;
  assign prog_clk   = prog_clk_r;
  assign ccff_head  = head_r;
  assign prog_reset = prst_r;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed self-checking bench for ccff_loader (CLK_DIV=4, FIFO_DEPTH=4).
module tb_ccff_loader;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb   = 1'b0;
  logic        cyc   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  adr   = 4'h0;
  logic [31:0] wdat  = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic        prog_clk;
  logic        prog_reset;
  logic        ccff_head;
  logic        ccff_tail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef CCFF_READBACK_EN
  logic chain_ff = 1'b0;
  always @(posedge prog_clk) chain_ff <= ccff_head;
  assign ccff_tail = chain_ff;
`else
  assign ccff_tail = 1'b0;
`endif

  ccff_loader #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input string tag);
    int lat;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check({tag, "_acklat"}, 64'(lat), 64'd1);
  endtask

  task automatic wb_read(input logic [3:0] a, input string tag, output logic [31:0] d);
    int lat;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
    lat = 0;
    d = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = i;
        d = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0;
    check({tag, "_acklat"}, 64'(lat), 64'd1);
  endtask

  // Watch prog_clk for up to ncyc cycles; capture ccff_head at each rise.
  task automatic run_shift(input int ncyc, input int stop_at, output int np,
                           output logic [63:0] cap, output int hi_min, output int hi_max,
                           output int lo_min, output int lo_max);
    logic prev, cur;
    int   run;
    bit   seen_fall;
    np = 0; cap = 64'h0; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    prev = prog_clk; run = 0; seen_fall = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      cur = prog_clk;
      if (cur === prev) begin
        run++;
      end else begin
        if (prev === 1'b1) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (seen_fall) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        if (cur === 1'b0) begin
          seen_fall = 1'b1;
        end else begin
          if (np < 64) cap[np] = ccff_head;
          np++;
        end
        run = 1;
      end
      prev = cur;
      if (stop_at != 0 && np == stop_at) break;
    end
  endtask

  localparam logic [3:0] A_CTRL = 4'h0, A_STAT = 4'h4, A_BCNT = 4'h8, A_DATA = 4'hC;

  logic [31:0] rd;
  logic [63:0] cap;
  int np, hmin, hmax, lmin, lmax;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_prog_clk", 64'(prog_clk), 64'd0);
    check("rst_head", 64'(ccff_head), 64'd0);
    check("rst_prog_reset", 64'(prog_reset), 64'd0);
    check("rst_dat", 64'(rdat), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    wb_read(A_STAT, "rst_status", rd);
    check("rst_status", 64'(rd), 64'h08);
    wb_read(A_BCNT, "rst_bitcnt", rd);
    check("rst_bitcnt", 64'(rd), 64'h0);

    // Five pushes into a 4-deep FIFO: overflow, each acked in one cycle
    for (int k = 0; k < 5; k++) wb_write(A_DATA, 32'h1000 + 32'(k), "ovf_push");
    wb_read(A_STAT, "ovf_status", rd);
    check("ovf_status", 64'(rd), 64'h24);

    // Start with BITCNT==0 goes straight to done and clears ovf
    wb_write(A_CTRL, 32'h1, "zero_start");
    wb_read(A_STAT, "zero_status", rd);
    check("zero_status", 64'(rd), 64'h06);

    // Abort flushes FIFO and clears done
    wb_write(A_CTRL, 32'h2, "flush_abort");
    wb_read(A_STAT, "flush_status", rd);
    check("flush_status", 64'(rd), 64'h08);

    // Single 32-bit word
    wb_write(A_BCNT, 32'd32, "w1_bcnt");
    wb_write(A_DATA, 32'hA5A5_0001, "w1_push");
    wb_write(A_CTRL, 32'h1, "w1_start");
    run_shift(300, 0, np, cap, hmin, hmax, lmin, lmax);
    check("w1_pulses", 64'(np), 64'd32);
    check("w1_bits", cap, 64'h0000_0000_A5A5_0001);
    check("w1_hi_min", 64'(hmin), 64'd4);
    check("w1_hi_max", 64'(hmax), 64'd4);
    check("w1_lo_min", 64'(lmin), 64'd4);
    check("w1_lo_max", 64'(lmax), 64'd4);
    check("w1_clk_idle", 64'(prog_clk), 64'd0);
    wb_read(A_STAT, "w1_status", rd);
    check("w1_status", 64'(rd), 64'h0A);

    // 40 bits over two words: upper 24 bits of word 2 are discarded
    wb_write(A_BCNT, 32'd40, "w40_bcnt");
    wb_write(A_DATA, 32'h0F0F_3C3C, "w40_push1");
    wb_write(A_DATA, 32'hABCD_EF96, "w40_push2");
    wb_write(A_CTRL, 32'h1, "w40_start");
    run_shift(380, 0, np, cap, hmin, hmax, lmin, lmax);
    check("w40_pulses", 64'(np), 64'd40);
    check("w40_bits", cap, 64'h0000_0096_0F0F_3C3C);
    check("w40_hi_max", 64'(hmax), 64'd4);
    check("w40_lo_min", 64'(lmin), 64'd4);
    check("w40_lo_max", 64'(lmax), 64'd5);
    wb_read(A_STAT, "w40_status", rd);
    check("w40_status", 64'(rd), 64'h0A);

    // 64 bits with one word queued: stall, then resume
    wb_write(A_BCNT, 32'd64, "st_bcnt");
    wb_write(A_DATA, 32'h1357_9BDF, "st_push1");
    wb_write(A_CTRL, 32'h1, "st_start");
    run_shift(300, 0, np, cap, hmin, hmax, lmin, lmax);
    check("st_pulses1", 64'(np), 64'd32);
    check("st_bits1", cap, 64'h0000_0000_1357_9BDF);
    check("st_clk_low", 64'(prog_clk), 64'd0);
    wb_read(A_STAT, "st_status", rd);
    check("st_status", 64'(rd), 64'h19);
    wb_write(A_CTRL, 32'h1, "st_busy_start");
    wb_read(A_STAT, "st_status2", rd);
    check("st_status2", 64'(rd), 64'h19);
    wb_write(A_DATA, 32'h2468_ACE0, "st_push2");
    run_shift(300, 0, np, cap, hmin, hmax, lmin, lmax);
    check("st_pulses2", 64'(np), 64'd32);
    check("st_bits2", cap, 64'h0000_0000_2468_ACE0);
    wb_read(A_STAT, "st_done", rd);
    check("st_done", 64'(rd), 64'h0A);

    // Abort at pulse 10
    wb_write(A_BCNT, 32'd32, "ab_bcnt");
    wb_write(A_DATA, 32'h1111_1111, "ab_push1");
    wb_write(A_DATA, 32'h2222_2222, "ab_push2");
    wb_write(A_CTRL, 32'h1, "ab_start");
    run_shift(300, 10, np, cap, hmin, hmax, lmin, lmax);
    check("ab_pulses", 64'(np), 64'd10);
    check("ab_bits", cap, 64'h111);
    wb_write(A_CTRL, 32'h2, "ab_abort");
    check("ab_clk", 64'(prog_clk), 64'd0);
    check("ab_head", 64'(ccff_head), 64'd0);
    wb_read(A_STAT, "ab_status", rd);
    check("ab_status", 64'(rd), 64'h08);

    // Readback after 33 bits
    wb_write(A_BCNT, 32'd33, "rb_bcnt");
    wb_write(A_DATA, 32'h1234_5678, "rb_push1");
    wb_write(A_DATA, 32'h0000_0001, "rb_push2");
    wb_write(A_CTRL, 32'h1, "rb_start");
    run_shift(320, 0, np, cap, hmin, hmax, lmin, lmax);
    check("rb_pulses", 64'(np), 64'd33);
    wb_read(A_DATA, "rb_data", rd);
`ifdef CCFF_READBACK_EN
    check("rb_data", 64'(rd), 64'h1234_5678);
`else
    check("rb_data", 64'(rd), 64'h0);
`endif

    // prog_reset follows CTRL bit2; BITCNT is 20 bits wide
    wb_write(A_CTRL, 32'h4, "prst_on");
    check("prst_on", 64'(prog_reset), 64'd1);
    wb_write(A_CTRL, 32'h0, "prst_off");
    check("prst_off", 64'(prog_reset), 64'd0);
    wb_write(A_BCNT, 32'hFFFF_FFFF, "bcnt_w");
    wb_read(A_BCNT, "bcnt_r", rd);
    check("bcnt_r", 64'(rd), 64'h000F_FFFF);

    // Asynchronous reset mid-shift
    wb_write(A_BCNT, 32'd32, "ar_bcnt");
    wb_write(A_DATA, 32'hAAAA_5555, "ar_push");
    wb_write(A_CTRL, 32'h1, "ar_start");
    run_shift(300, 3, np, cap, hmin, hmax, lmin, lmax);
    check("ar_pulses", 64'(np), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_clk", 64'(prog_clk), 64'd0);
    check("ar_head", 64'(ccff_head), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wb_read(A_STAT, "ar_status", rd);
    check("ar_status", 64'(rd), 64'h08);
    wb_read(A_BCNT, "ar_bitcnt", rd);
    check("ar_bitcnt", 64'(rd), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: prog_clk half-period in wb_clk_i cycles, legal range 1..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: depth of the 32-bit bitstream word FIFO, power of two, range 2..16.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, inputs, 1 bit each: Wishbone strobe, cycle and write-enable.
REQ-006 SHALL have port wbs_adr_i, input, 4 bits: byte address; only bits [3:2] are decoded.
REQ-007 SHALL have port wbs_dat_i, input, 32 bits: Wishbone write data.
REQ-008 SHALL have ports wbs_ack_o (output, 1 bit) and wbs_dat_o (output, 32 bits): Wishbone acknowledge and read data.
REQ-009 SHALL have ports prog_clk (output, 1), prog_reset (output, 1) and ccff_head (output, 1): configuration clock, configuration reset and chain serial input.
REQ-010 SHALL have port ccff_tail, input, 1 bit: chain serial output.

Function
REQ-011 Register map: 0x0 CTRL (write-only), 0x4 STATUS (read-only), 0x8 BITCNT (read/write), 0xC DATA (write pushes FIFO; read returns readback).
- CTRL bits: bit0 start, bit1 abort, bit2 prog_reset level.
- STATUS bits: bit0 busy, bit1 done, bit2 fifo_full, bit3 fifo_empty, bit4 stalled.
- BITCNT: [19:0], total number of bits to shift.
REQ-012 wbs_ack_o SHALL pulse high exactly one cycle, in the cycle after the first cycle of stb&cyc; there are no back-to-back acks within one transfer; wbs_dat_o is valid with the ack.
REQ-013 A DATA write when the FIFO is full SHALL be acked and dropped, and set sticky STATUS bit5 ovf, which is cleared by a start.
REQ-014 prog_reset SHALL follow CTRL bit2 directly and is independent of the FSM.
REQ-015 The FSM SHALL have states IDLE, FETCH, SHIFT_LO, SHIFT_HI and DONE.
REQ-016 IDLE -> FETCH on start when BITCNT != 0. Start with BITCNT == 0 SHALL go directly to DONE. Start while busy SHALL be ignored.
REQ-017 FETCH SHALL pop one FIFO word into a 32-bit shift register and go to SHIFT_LO. If the FIFO is empty it SHALL hold in FETCH with stalled=1 and prog_clk low.
REQ-018 SHIFT_LO SHALL drive ccff_head = shift_reg[0] (LSB first) and prog_clk=0 for CLK_DIV cycles, then go to SHIFT_HI.
REQ-019 SHIFT_HI SHALL drive prog_clk=1 for CLK_DIV cycles, then shift the register right and decrement the remaining-bit counter. Next state:
- remaining == 0 -> DONE;
- 32 bits of the current word consumed -> FETCH;
- otherwise -> SHIFT_LO.
REQ-020 DONE SHALL set done=1 and busy=0, then go to IDLE. done stays set until the next start.
REQ-021 BITCNT not a multiple of 32 SHALL leave the unused upper bits of the last word unshifted and discarded.
REQ-022 Abort SHALL take priority over every other event in any state. Within one cycle it SHALL force IDLE, prog_clk=0 and ccff_head=0, flush the FIFO, and leave done=0.
REQ-023 A simultaneous DATA push and FSM pop SHALL both succeed, with the FIFO count unchanged.
REQ-024 prog_clk and ccff_head SHALL be driven directly from flops, with no glitches.

Reset
REQ-025 While wb_rst_ni is low, all outputs SHALL be 0, the FSM SHALL be in IDLE, the FIFO SHALL be empty, BITCNT SHALL be 0 and all status bits SHALL be clear. fifo_empty SHALL read 1 after reset.
REQ-026 Reset assertion mid-shift SHALL drop prog_clk low asynchronously. No partial-bit recovery is required.

Configuration
REQ-027 With macro CCFF_READBACK_EN defined, ccff_tail SHALL be sampled on every prog_clk rising edge into a 32-bit register, shifted in at bit31 and shifted right. A DATA read SHALL return that register.
REQ-028 Without CCFF_READBACK_EN, ccff_tail SHALL be unused and a DATA read SHALL return 32'h0.

Structure
REQ-029 A shared package ccff_loader_pkg SHALL hold:
- register offset constants;
- STATUS/CTRL bit-index constants;
- the FSM state enum.
REQ-030 The FIFO SHALL be a separate sub-module ccff_word_fifo, parameterised by width and depth, with push/pop/full/empty and a count output.

Verification
REQ-031 Push 32'hA5A5_0001, BITCNT=32, CLK_DIV=4, start:
- ccff_head shows bits 1,0,0,0,...,1,0,1 LSB first;
- 32 prog_clk pulses, each 4 cycles high and 4 cycles low;
- done=1.
REQ-032 BITCNT=40 with two pushed words -> exactly 40 prog_clk pulses; the upper 24 bits of word 2 are never driven.
REQ-033 BITCNT=64, one word pushed, start -> stalled=1 after 32 pulses with prog_clk held low; pushing a second word resumes shifting, and done follows 32 further pulses.
REQ-034 Abort at pulse 10 of 32 -> next cycle prog_clk=0, busy=0, fifo_empty=1, done=0.
REQ-035 With CCFF_READBACK_EN, ccff_tail tied to ccff_head through a 1-flop chain model, shift 32'h1234_5678 then 1 extra bit -> DATA read returns the expected shifted pattern 32'h1234_5678>>... computed by the model. Without the macro, a DATA read returns 0.
REQ-036 Five DATA writes with FIFO_DEPTH=4 and no start -> fifo_full=1 and ovf=1; each write is acked in one cycle.
